// File: rtl/br_update_queue_if.sv
// Handshake bundle between execute lanes, branch-update queue and PHT write port.
interface br_update_queue_if #(
  parameter int unsigned Depth = 8,
  parameter int unsigned IdxW  = 9,
  parameter int unsigned HistW = 9,
  parameter int unsigned CntW  = 2
);
  localparam int unsigned CountW = $clog2(Depth + 1);

  logic [1:0]         in_valid;
  logic [2*IdxW-1:0]  in_idx;
  logic [2*HistW-1:0] in_hist;
  logic [2*CntW-1:0]  in_cnt;
  logic [1:0]         in_taken;
  logic               in_ready;

  logic               out_valid;
  logic               out_ready;
  logic [IdxW-1:0]    out_idx;
  logic [HistW-1:0]   out_hist;
  logic [CntW-1:0]    out_cnt;

  logic [CountW-1:0]  count;
  logic [7:0]         drop_count;

  // Producer side: execute lanes plus predictor ready.
  modport master (
    output in_valid, in_idx, in_hist, in_cnt, in_taken, out_ready,
    input  in_ready, out_valid, out_idx, out_hist, out_cnt, count, drop_count
  );

  // Queue side.
  modport slave (
    input  in_valid, in_idx, in_hist, in_cnt, in_taken, out_ready,
    output in_ready, out_valid, out_idx, out_hist, out_cnt, count, drop_count
  );
endinterface

// File: rtl/br_update_queue.sv
// Branch-update queue: takes up to two resolved branches per cycle, computes the
// saturated counter update, merges same-slot pairs and drains one update per cycle.
module br_update_queue #(
  parameter int unsigned Depth = 8,
  parameter int unsigned IdxW  = 9,
  parameter int unsigned HistW = 9,
  parameter int unsigned CntW  = 2
) (
  input logic              clk_i,
  input logic              rst_i,
  br_update_queue_if.slave bus_io
);

  localparam int unsigned PtrW   = $clog2(Depth);
  localparam int unsigned CountW = $clog2(Depth + 1);
  localparam logic [CntW-1:0] CntMax = {CntW{1'b1}};

  function automatic logic [CntW-1:0] cnt_upd(input logic [CntW-1:0] c, input logic t);
    if (t) return (c == CntMax) ? c : c + CntW'(1);
    else   return (c == '0)     ? c : c - CntW'(1);
  endfunction

  logic [IdxW-1:0]  idx_mem_q  [Depth];
  logic [HistW-1:0] hist_mem_q [Depth];
  logic [CntW-1:0]  cnt_mem_q  [Depth];

  logic [PtrW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CountW-1:0] count_q, count_d;
  logic [7:0]        drop_q, drop_d;
  logic [IdxW-1:0]   last_idx_q;
  logic [HistW-1:0]  last_hist_q;
  logic [CntW-1:0]   last_cnt_q;

  logic             v0, v1, t0, t1, merge, in_ready, out_valid, deq;
  logic [IdxW-1:0]  idx0, idx1;
  logic [HistW-1:0] hist0, hist1;
  logic [CntW-1:0]  cnt0, cnt1, new0, new1;
  logic [1:0]       enq_n, drop_n;
  logic [8:0]       drop_sum;

  logic             wr0_en, wr1_en;
  logic [PtrW-1:0]  wr0_ptr, wr1_ptr;
  logic [IdxW-1:0]  wr0_idx, wr1_idx;
  logic [HistW-1:0] wr0_hist, wr1_hist;
  logic [CntW-1:0]  wr0_cnt, wr1_cnt;

  assign v0    = bus_io.in_valid[0];
  assign v1    = bus_io.in_valid[1];
  assign t0    = bus_io.in_taken[0];
  assign t1    = bus_io.in_taken[1];
  assign idx0  = bus_io.in_idx[IdxW-1:0];
  assign idx1  = bus_io.in_idx[2*IdxW-1:IdxW];
  assign hist0 = bus_io.in_hist[HistW-1:0];
  assign hist1 = bus_io.in_hist[2*HistW-1:HistW];
  assign cnt0  = bus_io.in_cnt[CntW-1:0];
  assign cnt1  = bus_io.in_cnt[2*CntW-1:CntW];

  // Enqueue decode: counter updates, merge detection, write ports and drop accounting.
  always_comb begin
    in_ready = (count_q <= CountW'(Depth - 2));
    merge    = v0 && v1 && (idx0 == idx1) && (hist0 == hist1);
    new0     = cnt_upd(cnt0, t0);
    // A merged pair chains lane1's direction onto lane0's result.
    new1     = cnt_upd(merge ? new0 : cnt1, t1);

    wr0_en   = 1'b0;
    wr0_ptr  = tail_q;
    wr0_idx  = idx0;
    wr0_hist = hist0;
    wr0_cnt  = new0;
    wr1_en   = 1'b0;
    wr1_ptr  = tail_q + PtrW'(v0);
    wr1_idx  = idx1;
    wr1_hist = hist1;
    wr1_cnt  = new1;
    enq_n    = 2'd0;
    drop_n   = 2'd0;

    if (in_ready) begin
      if (merge) begin
        wr0_en  = 1'b1;
        wr0_cnt = new1;
        enq_n   = 2'd1;
      end else begin
        wr0_en = v0;
        wr1_en = v1;
        enq_n  = {1'b0, v0} + {1'b0, v1};
      end
    end else begin
      drop_n = {1'b0, v0} + {1'b0, v1};
    end

    drop_sum = {1'b0, drop_q} + 9'(drop_n);
    drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end

  // Dequeue side and pointer/occupancy next state.
  always_comb begin
    out_valid = (count_q != '0);
    deq       = out_valid && bus_io.out_ready;
    head_d    = head_q + PtrW'(deq);
    tail_d    = tail_q + PtrW'(enq_n);
    count_d   = count_q + CountW'(enq_n) - CountW'(deq);
  end

  assign bus_io.in_ready   = in_ready;
  assign bus_io.out_valid  = out_valid;
  assign bus_io.out_idx    = out_valid ? idx_mem_q[head_q]  : last_idx_q;
  assign bus_io.out_hist   = out_valid ? hist_mem_q[head_q] : last_hist_q;
  assign bus_io.out_cnt    = out_valid ? cnt_mem_q[head_q]  : last_cnt_q;
  assign bus_io.count      = count_q;
  assign bus_io.drop_count = drop_q;

  // Control state; the last shown head is kept so out_* hold while empty.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      drop_q      <= '0;
      last_idx_q  <= '0;
      last_hist_q <= '0;
      last_cnt_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      drop_q  <= drop_d;
      if (out_valid) begin
        last_idx_q  <= idx_mem_q[head_q];
        last_hist_q <= hist_mem_q[head_q];
        last_cnt_q  <= cnt_mem_q[head_q];
      end
    end
  end

  // Entry storage; contents need no reset because count gates visibility.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (wr0_en) begin
        idx_mem_q[wr0_ptr]  <= wr0_idx;
        hist_mem_q[wr0_ptr] <= wr0_hist;
        cnt_mem_q[wr0_ptr]  <= wr0_cnt;
      end
      if (wr1_en) begin
        idx_mem_q[wr1_ptr]  <= wr1_idx;
        hist_mem_q[wr1_ptr] <= wr1_hist;
        cnt_mem_q[wr1_ptr]  <= wr1_cnt;
      end
    end
  end

endmodule

// File: tb/tb_br_update_queue.sv
// Self-checking bench for br_update_queue: vector table plus a cycle model/scoreboard.
module tb_br_update_queue;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  br_update_queue_if #(.Depth(8), .IdxW(9), .HistW(9), .CntW(2)) bus ();

  br_update_queue #(.Depth(8), .IdxW(9), .HistW(9), .CntW(2)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus_io(bus)
  );

  typedef struct {
    logic [1:0] v;
    int i0, h0, c0, t0, i1, h1, c1, t1;
    int e_count, e_idx, e_hist, e_cnt;
  } vec_t;

  typedef struct {
    int idx, hist, cnt;
  } ent_t;

  vec_t vecs[9];
  ent_t exp_q[$];
  ent_t model_last;
  int   model_drop;
  int   n_err = 0;
  int   n_checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int exp_upd(input int c, input int t);
    if (t != 0) return (c >= 3) ? 3 : c + 1;
    return (c <= 0) ? 0 : c - 1;
  endfunction

  task automatic drive(input logic [1:0] v, input int i0, input int h0, input int c0,
                       input int t0, input int i1, input int h1, input int c1, input int t1,
                       input logic rdy);
    bus.in_valid  = v;
    bus.in_idx    = {9'(i1), 9'(i0)};
    bus.in_hist   = {9'(h1), 9'(h0)};
    bus.in_cnt    = {2'(c1), 2'(c0)};
    bus.in_taken  = {1'(t1), 1'(t0)};
    bus.out_ready = rdy;
  endtask

  task automatic idle(input logic rdy);
    drive(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, rdy);
  endtask

  // Compare every visible output against the model state.
  task automatic check_state();
    ent_t head;
    int   sz;
    sz = exp_q.size();
    head = (sz != 0) ? exp_q[0] : model_last;
    chk("count", 32'(bus.count), 32'(sz));
    chk("in_ready", 32'(bus.in_ready), 32'(sz <= 6));
    chk("out_valid", 32'(bus.out_valid), 32'(sz != 0));
    chk("drop_count", 32'(bus.drop_count), 32'(model_drop));
    chk("out_idx", 32'(bus.out_idx), 32'(head.idx));
    chk("out_hist", 32'(bus.out_hist), 32'(head.hist));
    chk("out_cnt", 32'(bus.out_cnt), 32'(head.cnt));
    if (sz != 0) model_last = exp_q[0];
  endtask

  // Advance the reference model by one clock using the currently driven inputs.
  task automatic model_step();
    int   i0, i1, h0, h1, c0, c1, t0, t1, ndrop;
    ent_t e;
    if (rst) begin
      exp_q.delete();
      model_drop = 0;
      model_last = '{0, 0, 0};
      return;
    end
    i0 = int'(bus.in_idx[8:0]);   i1 = int'(bus.in_idx[17:9]);
    h0 = int'(bus.in_hist[8:0]);  h1 = int'(bus.in_hist[17:9]);
    c0 = int'(bus.in_cnt[1:0]);   c1 = int'(bus.in_cnt[3:2]);
    t0 = int'(bus.in_taken[0]);   t1 = int'(bus.in_taken[1]);
    if (exp_q.size() <= 6) begin
      if (exp_q.size() != 0 && bus.out_ready) void'(exp_q.pop_front());
      if (bus.in_valid == 2'b11 && i0 == i1 && h0 == h1) begin
        e = '{i0, h0, exp_upd(exp_upd(c0, t0), t1)};
        exp_q.push_back(e);
      end else begin
        if (bus.in_valid[0]) begin e = '{i0, h0, exp_upd(c0, t0)}; exp_q.push_back(e); end
        if (bus.in_valid[1]) begin e = '{i1, h1, exp_upd(c1, t1)}; exp_q.push_back(e); end
      end
    end else begin
      if (exp_q.size() != 0 && bus.out_ready) void'(exp_q.pop_front());
      ndrop = int'(bus.in_valid[0]) + int'(bus.in_valid[1]);
      model_drop = (model_drop + ndrop > 255) ? 255 : model_drop + ndrop;
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_state();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    idle(1'b1);
    for (int n = 0; n < 12 && exp_q.size() != 0; n++) step();
    chk("drained_count", 32'(bus.count), 32'd0);
    idle(1'b0);
  endtask

  initial begin
    //          v      i0  h0 c0 t0  i1 h1 c1 t1  cnt idx hist ocnt
    vecs[0] = '{2'b01,  5, 3, 1, 1,  0, 0, 0, 0,  1,  5,  3, 2};
    vecs[1] = '{2'b01, 11, 2, 3, 1,  0, 0, 0, 0,  1, 11,  2, 3};
    vecs[2] = '{2'b01, 12, 0, 0, 0,  0, 0, 0, 0,  1, 12,  0, 0};
    vecs[3] = '{2'b01, 13, 8, 2, 0,  0, 0, 0, 0,  1, 13,  8, 1};
    vecs[4] = '{2'b11,  7, 1, 2, 1,  7, 1, 0, 1,  1,  7,  1, 3};
    vecs[5] = '{2'b11,  7, 1, 2, 1,  7, 1, 0, 0,  1,  7,  1, 2};
    vecs[6] = '{2'b11, 40, 5, 0, 0, 40, 5, 3, 1,  1, 40,  5, 1};
    vecs[7] = '{2'b10,  0, 0, 0, 0,  9, 4, 1, 0,  1,  9,  4, 0};
    vecs[8] = '{2'b11, 20, 1, 1, 0, 20, 2, 2, 1,  2, 20,  1, 0};

    model_drop = 0;
    model_last = '{0, 0, 0};
    idle(1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    step();  // reset state checked against empty model

    // Single-entry vectors, each from an empty queue.
    for (int k = 0; k < 9; k++) begin
      drive(vecs[k].v, vecs[k].i0, vecs[k].h0, vecs[k].c0, vecs[k].t0,
            vecs[k].i1, vecs[k].h1, vecs[k].c1, vecs[k].t1, 1'b0);
      step();
      idle(1'b0);
      chk("vec_count", 32'(bus.count), 32'(vecs[k].e_count));
      chk("vec_idx", 32'(bus.out_idx), 32'(vecs[k].e_idx));
      chk("vec_hist", 32'(bus.out_hist), 32'(vecs[k].e_hist));
      chk("vec_cnt", 32'(bus.out_cnt), 32'(vecs[k].e_cnt));
      drain();
      chk("vec_empty_valid", 32'(bus.out_valid), 32'd0);
    end

    // Fill with four dual pushes, then a dropped fifth, then drain across wrap.
    for (int j = 0; j < 4; j++) begin
      drive(2'b11, 100 + 2 * j, j, j % 4, 1, 101 + 2 * j, j + 8, 3 - (j % 4), 0, 1'b0);
      step();
    end
    chk("fill_count", 32'(bus.count), 32'd8);
    chk("fill_ready", 32'(bus.in_ready), 32'd0);
    drive(2'b11, 200, 0, 1, 1, 201, 0, 1, 1, 1'b0);
    step();
    chk("fill_drop", 32'(bus.drop_count), 32'd2);
    chk("fill_count_after_drop", 32'(bus.count), 32'd8);
    drain();

    // Concurrent dual enqueue and dequeue at count 6, then full-boundary drop.
    for (int j = 0; j < 3; j++) begin
      drive(2'b11, 300 + j, 1, 1, 1, 310 + j, 2, 2, 0, 1'b0);
      step();
    end
    chk("conc_pre_count", 32'(bus.count), 32'd6);
    drive(2'b11, 320, 3, 0, 1, 321, 3, 0, 0, 1'b1);
    step();
    chk("conc_count", 32'(bus.count), 32'd7);
    chk("conc_ready", 32'(bus.in_ready), 32'd0);
    drive(2'b01, 330, 0, 2, 1, 0, 0, 0, 0, 1'b0);
    step();
    chk("boundary_drop", 32'(bus.drop_count), 32'd3);
    chk("boundary_count", 32'(bus.count), 32'd7);
    drain();

    // Reset in the middle of a drain.
    drive(2'b11, 400, 1, 1, 1, 401, 1, 1, 1, 1'b0); step();
    drive(2'b11, 402, 1, 1, 0, 403, 1, 1, 0, 1'b0); step();
    drive(2'b01, 404, 1, 2, 1, 0, 0, 0, 0, 1'b0);   step();
    chk("rst_pre_count", 32'(bus.count), 32'd5);
    idle(1'b1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_drop", 32'(bus.drop_count), 32'd0);
    chk("rst_out_idx", 32'(bus.out_idx), 32'd0);
    drive(2'b01, 33, 6, 2, 1, 0, 0, 0, 0, 1'b0);
    step();
    idle(1'b0);
    chk("post_rst_idx", 32'(bus.out_idx), 32'd33);
    chk("post_rst_cnt", 32'(bus.out_cnt), 32'd3);
    drain();
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
